fpu_addsub_special_pipe: RTL

FPU_ADDSUB_SPECIAL_PIPE -- requirements
Module: fpu_addsub_special_pipe

---
 rtl/fpu_addsub_special_pipe_if.sv | 41 ++++
 rtl/fpu_addsub_special_pipe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_special_pipe_if.sv
// Operand/result handshake bundle for fpu_addsub_special_pipe.
//   master : producer/consumer side (drives operands, flush, out_ready, sticky clear)
//   slave  : the special-case pipeline itself
// Signals:
//   flush_i       drop all in-flight beats
//   in_valid_i / in_ready_o      operand beat handshake
//   op_a_i, op_b_i, sub_op_i, rm_i   operands, A-B select, rounding mode
//   out_valid_o / out_ready_i    result beat handshake
//   fast_sel_o, fast_res_o, nv_o     special-case result and invalid flag
//   nv_sticky_o, sticky_clr_i    accumulated invalid flag and its clear
interface fpu_addsub_special_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] op_a_i;
    logic [W-1:0] op_b_i;
    logic         sub_op_i;
    logic [2:0]   rm_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic         fast_sel_o;
    logic [W-1:0] fast_res_o;
    logic         nv_o;
    logic         nv_sticky_o;
    logic         sticky_clr_i;

    modport master (
        output flush_i, in_valid_i, op_a_i, op_b_i, sub_op_i, rm_i, out_ready_i, sticky_clr_i,
        input  in_ready_o, out_valid_o, fast_sel_o, fast_res_o, nv_o, nv_sticky_o
    );

    modport slave (
        input  flush_i, in_valid_i, op_a_i, op_b_i, sub_op_i, rm_i, out_ready_i, sticky_clr_i,
        output in_ready_o, out_valid_o, fast_sel_o, fast_res_o, nv_o, nv_sticky_o
    );
endinterface

// File: rtl/fpu_addsub_special_pipe.sv
// Two-stage special-case resolver for IEEE add/subtract. Detects NaN/inf/zero
// combinations and produces the final result directly (fast_sel_o=1); for two
// finite nonzero operands it reports that the main datapath is required.
//   clk_i    single clock, rising edge
//   reset_i  asynchronous, active-high reset
//   bus      fpu_addsub_special_pipe_if slave modport (handshakes, operands, results)
// Build option: define FPU_FAST_DAZ_EN to treat subnormal operands as signed zeros.
module fpu_addsub_special_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic                      clk_i,
    input logic                      reset_i,
    fpu_addsub_special_pipe_if.slave bus
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] CanonNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0] InfMag   = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } cls_t;

    function automatic cls_t classify(input logic [W-1:0] op);
        cls_t c;
        logic exp_zero;
        logic exp_ones;
        logic man_zero;
        exp_zero = (op[W-2 -: EXP_W] == '0);
        exp_ones = &op[W-2 -: EXP_W];
        man_zero = (op[MAN_W-1:0] == '0);
`ifdef FPU_FAST_DAZ_EN
        c.zero = exp_zero;
`else
        c.zero = exp_zero && man_zero;
`endif
        c.inf  = exp_ones && man_zero;
        c.nan  = exp_ones && !man_zero;
        c.snan = c.nan && !op[MAN_W-1];
        return c;
    endfunction

    // Stage 1: classification and operands
    logic         r_s1_v;
    logic [W-1:0] r_s1_a;
    logic [W-1:0] r_s1_b;
    logic         r_s1_sub;
    logic [2:0]   r_s1_rm;
    cls_t         r_s1_cls_a;
    cls_t         r_s1_cls_b;

    // Stage 2: result and flags
    logic         r_s2_v;
    logic         r_s2_fast_sel;
    logic [W-1:0] r_s2_res;
    logic         r_s2_nv;
    logic         r_nv_sticky;

    logic         w_s2_adv;
    logic         w_s1_adv;
    logic         w_out_hs;
    logic         w_sign_a;
    logic         w_sign_b;
    logic         w_fast_sel;
    logic [W-1:0] w_res;
    logic         w_nv;

    assign w_s2_adv = !r_s2_v || bus.out_ready_i;
    assign w_s1_adv = !r_s1_v || w_s2_adv;
    assign w_out_hs = r_s2_v && bus.out_ready_i;

    always_comb begin
        w_fast_sel = 1'b1;
        w_res      = '0;
        w_nv       = 1'b0;
        w_sign_a   = r_s1_a[W-1];
        w_sign_b   = r_s1_b[W-1] ^ r_s1_sub;
        if (r_s1_cls_a.nan || r_s1_cls_b.nan) begin
            w_res = CanonNan;
            w_nv  = r_s1_cls_a.snan || r_s1_cls_b.snan;
        end else if (r_s1_cls_a.inf && r_s1_cls_b.inf) begin
            if (w_sign_a == w_sign_b) begin
                w_res = {w_sign_a, InfMag};
            end else begin
                w_res = CanonNan;
                w_nv  = 1'b1;
            end
        end else if (r_s1_cls_a.inf) begin
            w_res = {w_sign_a, InfMag};
        end else if (r_s1_cls_b.inf) begin
            w_res = {w_sign_b, InfMag};
        end else if (r_s1_cls_a.zero && r_s1_cls_b.zero) begin
            // Exact cancellation of opposite zeros gives -0 only when rounding down
            w_res = {(w_sign_a == w_sign_b) ? w_sign_a : (r_s1_rm == 3'b010), {(W-1){1'b0}}};
        end else if (r_s1_cls_a.zero) begin
            w_res = {w_sign_b, r_s1_b[W-2:0]};
        end else if (r_s1_cls_b.zero) begin
            w_res = {w_sign_a, r_s1_a[W-2:0]};
        end else begin
            w_fast_sel = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s1_v        <= 1'b0;
            r_s1_a        <= '0;
            r_s1_b        <= '0;
            r_s1_sub      <= 1'b0;
            r_s1_rm       <= '0;
            r_s1_cls_a    <= '0;
            r_s1_cls_b    <= '0;
            r_s2_v        <= 1'b0;
            r_s2_fast_sel <= 1'b0;
            r_s2_res      <= '0;
            r_s2_nv       <= 1'b0;
        end else if (bus.flush_i) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_v <= bus.in_valid_i;
                if (bus.in_valid_i) begin
                    r_s1_a     <= bus.op_a_i;
                    r_s1_b     <= bus.op_b_i;
                    r_s1_sub   <= bus.sub_op_i;
                    r_s1_rm    <= bus.rm_i;
                    r_s1_cls_a <= classify(bus.op_a_i);
                    r_s1_cls_b <= classify(bus.op_b_i);
                end
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                // Bubbles keep the old payload so idle outputs do not toggle
                if (r_s1_v) begin
                    r_s2_fast_sel <= w_fast_sel;
                    r_s2_res      <= w_res;
                    r_s2_nv       <= w_nv;
                end
            end
        end
    end

    // Set has priority over clear; a flushed beat never reaches the flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_nv_sticky <= 1'b0;
        end else if (w_out_hs && r_s2_nv && !bus.flush_i) begin
            r_nv_sticky <= 1'b1;
        end else if (bus.sticky_clr_i) begin
            r_nv_sticky <= 1'b0;
        end
    end

    assign bus.in_ready_o  = w_s1_adv;
    assign bus.out_valid_o = r_s2_v;
    assign bus.fast_sel_o  = r_s2_fast_sel;
    assign bus.fast_res_o  = r_s2_res;
    assign bus.nv_o        = r_s2_nv;
    assign bus.nv_sticky_o = r_nv_sticky;
endmodule
